irom_fetch_queue: RTL and testbench
===================================

Name: irom_fetch_queue

Overview:
- Instruction prefetch queue between the IROM (combinational word-read ROM, 14-bit word address, 32-bit data) and the CPU IF stage.
- Owns the fetch PC, reads one word per cycle into a small FIFO, and presents {pc, instr} pairs to IF through a valid/ready handshake.
- A redirect input (branch/jump resolved in EX) flushes the queue and restarts fetch at the target.
- Decouples IF stalls from ROM addressing, so the core no longer drives the IROM address directly.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- ADDR_W, 14, IROM word-address width.
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset; bits [1:0] must be 0.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- irom_addr  out  ADDR_W  word address to the IROM; equals fetch_pc[ADDR_W+1:2], combinational from the fetch_pc register.
- irom_data  in  32  IROM read data for irom_addr, valid in the same cycle.
- redirect_valid  in  1  flush the queue and restart fetch.
- redirect_pc  in  32  restart target; bits [1:0] ignored (treated as 0).
- out_valid  out  1  head entry available to IF.
- out_pc  out  32  PC of the head entry.
- out_instr  out  32  instruction of the head entry.
- out_ready  in  1  IF accepts the head this cycle.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Behaviour:
- State: fetch_pc (32b), wr_ptr/rd_ptr ($clog2(DEPTH) bits, natural wrap), count, DEPTH x 64b storage {pc, instr}.
- Reset (rst=1 at a clk edge):
  - fetch_pc <= RESET_PC; pointers and count <= 0.
  - Storage contents are don't-care.
  - Overrides redirect and every handshake in the same cycle.
- Outputs after reset: out_valid=0, count=0, irom_addr=RESET_PC[ADDR_W+1:2]. out_pc and out_instr are don't-care while out_valid=0.
- out_valid = (count != 0) && !redirect_valid. out_pc and out_instr always show storage[rd_ptr].
- pop = out_valid && out_ready.
- push = !redirect_valid && (count < DEPTH || pop).
  - Storage[wr_ptr] <= {fetch_pc, irom_data}; wr_ptr++; fetch_pc <= fetch_pc + 4.
  - fetch_pc wraps modulo 2^32; irom_addr truncates naturally.
- Full with simultaneous pop: push is allowed and count stays DEPTH, so steady-state throughput is 1/cycle.
- Redirect (redirect_valid=1, rst=0):
  - Pointers and count <= 0.
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - No push and no pop that cycle; out_ready is ignored.
  - A redirect while empty behaves identically.
  - Back-to-back redirects: the last one wins.
- Latency:
  - First out_valid comes 1 cycle after reset release or after a redirect cycle; the entry has pc = restart PC.
  - With out_ready held high, entry pc advances by +4 every cycle with no bubbles.
- count update: count + push - pop, with no overflow and no underflow by construction.
- No combinational path from out_ready to irom_addr. out_valid depends combinationally on redirect_valid only.

Test Plan:
- Reset, out_ready=1, IROM word k = 0x1000_0000+k:
  - No out_valid in the first cycle after rst falls.
  - Then out_pc = 0,4,8,... with out_instr = 0x1000_0000,0x1000_0001,... on consecutive cycles, no gaps.
- out_ready=0 for 10 cycles after reset:
  - count climbs 1,2,3,4 then holds 4; irom_addr freezes at word 4.
  - Releasing out_ready drains pc 0,4,8,12 in order, then pc 16 follows with no bubble.
- Full queue (count=4), out_ready=1 for one cycle:
  - One pop (pc 0) and one push (pc 16); count stays 4.
- Mid-stream redirect_valid=1, redirect_pc=0x0000_0102 while count=3:
  - out_valid=0 that cycle and count=0 next.
  - Next head has pc=0x100 and out_instr = IROM word 0x40; no stale entries ever emitted.
- Redirect and out_ready=1 asserted together with count=2:
  - No handshake counted; only post-redirect entries appear.
- rst asserted while full with redirect_valid=1 and redirect_pc=0x200:
  - Next cycle count=0 and fetch restarts at RESET_PC, not 0x200.
- Wrap: redirect_pc=0xFFFF_FFFC:
  - Entries show pc 0xFFFF_FFFC then 0x0000_0000.
  - irom_addr goes 0x3FFF then 0x0000.

Source files
------------

// File: rtl/irom_fetch_queue_if.sv
// IF-side and IROM-side signal bundle for the instruction prefetch queue.
// master = the queue, slave = the IROM/IF environment around it.
interface irom_fetch_queue_if #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 14
);
    logic [ADDR_W-1:0]        irom_addr;
    logic [31:0]              irom_data;
    logic                     redirect_valid;
    logic [31:0]              redirect_pc;
    logic                     out_valid;
    logic [31:0]              out_pc;
    logic [31:0]              out_instr;
    logic                     out_ready;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output irom_addr,
        input  irom_data,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        output out_pc,
        output out_instr,
        input  out_ready,
        output count
    );

    modport slave (
        input  irom_addr,
        output irom_data,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        input  out_pc,
        input  out_instr,
        output out_ready,
        input  count
    );
endinterface

// File: rtl/irom_fetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, reads one IROM word per cycle into a
// small FIFO and hands {pc, instr} pairs to IF; a redirect flushes and restarts fetch.
module irom_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned ADDR_W   = 14,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic                clk,
    input logic                rst,
    irom_fetch_queue_if.master bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("irom_fetch_queue: DEPTH must be a power of two >= 2");
    end
    if (ADDR_W + 2 > 32) begin : g_bad_addr_w
        $error("irom_fetch_queue: ADDR_W must be <= 30");
    end
    if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
        $error("irom_fetch_queue: RESET_PC must be word aligned");
    end

    logic [31:0]      fetch_pc_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [63:0]      mem_q [DEPTH];

    logic push;
    logic pop;

    assign bus.irom_addr = fetch_pc_q[ADDR_W+1:2];
    assign bus.count     = count_q;

    // A redirect hides the head in the same cycle so no stale entry is handed out.
    assign bus.out_valid = (count_q != '0) && !bus.redirect_valid;
    assign bus.out_pc    = mem_q[rd_ptr_q][63:32];
    assign bus.out_instr = mem_q[rd_ptr_q][31:0];

    assign pop  = bus.out_valid && bus.out_ready;
    // Pushing into a full queue is fine when the head leaves in the same cycle.
    assign push = !bus.redirect_valid && ((count_q < FULL) || pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else if (bus.redirect_valid) begin
            fetch_pc_q <= {bus.redirect_pc[31:2], 2'b00};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q   <= wr_ptr_q + PTR_W'(1);
                fetch_pc_q <= fetch_pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Storage needs no reset; entries are only observed once count covers them.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {fetch_pc_q, bus.irom_data};
        end
    end
endmodule

// File: tb/tb_irom_fetch_queue.sv
// Directed bench for irom_fetch_queue: per-cycle vector table plus a fill/drain sequence.
module tb_irom_fetch_queue;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    irom_fetch_queue_if #(.DEPTH(4), .ADDR_W(14)) bus ();

    irom_fetch_queue #(
        .DEPTH   (4),
        .ADDR_W  (14),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // IROM model: word k holds 0x1000_0000 + k.
    assign bus.irom_data = 32'h1000_0000 + {18'b0, bus.irom_addr};

    typedef struct {
        logic        rst;
        logic        redir;
        logic [31:0] rpc;
        logic        rdy;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [2:0]  e_count;
        logic [13:0] e_addr;
    } vec_t;

    vec_t vq[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic add(input logic r, input logic rd, input logic [31:0] rpc, input logic rdy,
                       input logic ev, input logic [31:0] epc, input logic [31:0] ein,
                       input logic [2:0] ecnt, input logic [13:0] eaddr);
        vec_t v;
        v.rst = r; v.redir = rd; v.rpc = rpc; v.rdy = rdy;
        v.e_valid = ev; v.e_pc = epc; v.e_instr = ein; v.e_count = ecnt; v.e_addr = eaddr;
        vq.push_back(v);
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check(input string tag, input logic ev, input logic [31:0] epc,
                         input logic [31:0] ein, input logic [2:0] ecnt,
                         input logic [13:0] eaddr);
        cmp({tag, " out_valid"}, {31'b0, bus.out_valid}, {31'b0, ev});
        cmp({tag, " count"}, {29'b0, bus.count}, {29'b0, ecnt});
        cmp({tag, " irom_addr"}, {18'b0, bus.irom_addr}, {18'b0, eaddr});
        if (ev) begin
            cmp({tag, " out_pc"}, bus.out_pc, epc);
            cmp({tag, " out_instr"}, bus.out_instr, ein);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.out_ready      = 1'b0;

        // rst redir rpc rdy | valid pc instr count addr
        // streaming from reset with out_ready high
        add(0, 0, 0, 1,  0, 0,  0,             0, 14'h0);
        add(0, 0, 0, 1,  1, 0,  32'h1000_0000, 1, 14'h1);
        add(0, 0, 0, 1,  1, 4,  32'h1000_0001, 1, 14'h2);
        add(0, 0, 0, 1,  1, 8,  32'h1000_0002, 1, 14'h3);
        // reset, then fill with out_ready low
        add(1, 0, 0, 0,  1, 12, 32'h1000_0003, 1, 14'h4);
        add(0, 0, 0, 0,  0, 0,  0,             0, 14'h0);
        add(0, 0, 0, 0,  1, 0,  32'h1000_0000, 1, 14'h1);
        add(0, 0, 0, 0,  1, 0,  32'h1000_0000, 2, 14'h2);
        add(0, 0, 0, 0,  1, 0,  32'h1000_0000, 3, 14'h3);
        add(0, 0, 0, 0,  1, 0,  32'h1000_0000, 4, 14'h4);
        add(0, 0, 0, 0,  1, 0,  32'h1000_0000, 4, 14'h4);
        // full: single pop+push keeps count at 4
        add(0, 0, 0, 1,  1, 0,  32'h1000_0000, 4, 14'h4);
        add(0, 0, 0, 0,  1, 4,  32'h1000_0001, 4, 14'h5);
        add(0, 0, 0, 1,  1, 4,  32'h1000_0001, 4, 14'h5);
        add(0, 0, 0, 1,  1, 8,  32'h1000_0002, 4, 14'h6);
        // reset, climb to count 3, redirect to 0x102
        add(1, 0, 0, 0,  1, 12, 32'h1000_0003, 4, 14'h7);
        add(0, 0, 0, 0,  0, 0,  0,             0, 14'h0);
        add(0, 0, 0, 0,  1, 0,  32'h1000_0000, 1, 14'h1);
        add(0, 0, 0, 0,  1, 0,  32'h1000_0000, 2, 14'h2);
        add(0, 1, 32'h0000_0102, 0,  0, 0, 0,  3, 14'h3);
        add(0, 0, 0, 0,  0, 0,  0,             0, 14'h40);
        add(0, 0, 0, 1,  1, 32'h100, 32'h1000_0040, 1, 14'h41);
        add(0, 0, 0, 0,  1, 32'h104, 32'h1000_0041, 1, 14'h42);
        // redirect with out_ready high at count 2
        add(0, 1, 32'h0000_0300, 1,  0, 0, 0,  2, 14'h43);
        add(0, 0, 0, 1,  0, 0,  0,             0, 14'hC0);
        add(0, 0, 0, 1,  1, 32'h300, 32'h1000_00C0, 1, 14'hC1);
        add(0, 0, 0, 0,  1, 32'h304, 32'h1000_00C1, 1, 14'hC2);
        add(0, 0, 0, 0,  1, 32'h304, 32'h1000_00C1, 2, 14'hC3);
        add(0, 0, 0, 0,  1, 32'h304, 32'h1000_00C1, 3, 14'hC4);
        // reset beats redirect while full
        add(1, 1, 32'h0000_0200, 1,  0, 0, 0,  4, 14'hC5);
        add(0, 0, 0, 1,  0, 0,  0,             0, 14'h0);
        add(0, 0, 0, 1,  1, 0,  32'h1000_0000, 1, 14'h1);
        // back-to-back redirects, last wins; then PC wrap
        add(0, 1, 32'h0000_0500, 1,  0, 0, 0,  1, 14'h2);
        add(0, 1, 32'hFFFF_FFFF, 1,  0, 0, 0,  0, 14'h140);
        add(0, 0, 0, 1,  0, 0,  0,             0, 14'h3FFF);
        add(0, 0, 0, 1,  1, 32'hFFFF_FFFC, 32'h1000_3FFF, 1, 14'h0);
        add(0, 0, 0, 1,  1, 32'h0000_0000, 32'h1000_0000, 1, 14'h1);

        repeat (2) @(posedge clk);

        foreach (vq[i]) begin
            @(negedge clk);
            rst                = vq[i].rst;
            bus.redirect_valid = vq[i].redir;
            bus.redirect_pc    = vq[i].rpc;
            bus.out_ready      = vq[i].rdy;
            #1;
            check($sformatf("vec%0d", i), vq[i].e_valid, vq[i].e_pc, vq[i].e_instr,
                  vq[i].e_count, vq[i].e_addr);
        end

        // Fill for 10 cycles with out_ready low, then drain with no bubbles.
        @(negedge clk);
        rst = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.out_ready      = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rst = 1'b0;
            #1;
            check($sformatf("fill%0d", i), i > 0, 32'h0, 32'h1000_0000,
                  3'((i < 4) ? i : 4), 14'((i < 4) ? i : 4));
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            #1;
            check($sformatf("drain%0d", k), 1'b1, 32'(4 * k), 32'h1000_0000 + 32'(k),
                  3'd4, 14'(4 + k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
